// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetches 1- or 2-byte instructions from program memory,
// hands the opcode to the microcode decoder, launches datapath execution and
// resolves conditional jumps. Halting is only allowed between instructions.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  input  logic       jump_operation,
  input  logic       jump_condition,
  input  logic       carry,
  input  logic       zero,
  output logic       exec_start,
  input  logic       exec_done,
  output logic [7:0] pc,
  input  logic       halt_req,
  output logic       halted
);

  localparam int unsigned W = 8;

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    FETCH_ARG = 3'd1,
    DECODE    = 3'd2,
    EXEC      = 3'd3,
    WAIT_DONE = 3'd4,
    HALT      = 3'd5
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] pc_nxt, opcode_nxt, operand_nxt;
  logic         flag_sel;
  logic         jump_taken;
  logic         fetch_ok;

  // Next-state, program counter and instruction register update
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    opcode_nxt  = opcode;
    operand_nxt = operand;
    // Bit0 of the opcode picks which flag a conditional jump tests
    flag_sel    = opcode[0] ? zero : carry;
    jump_taken  = jump_operation && (!jump_condition || flag_sel);
    // The registered request is low for one cycle after reset; ignore acks then
    fetch_ok    = mem_req && mem_ack;

    unique case (state)
      FETCH_OP: begin
        if (fetch_ok) begin
          opcode_nxt = mem_rdata;
          pc_nxt     = W'(pc + W'(1));
          if (mem_rdata[7]) begin
            state_nxt = FETCH_ARG;
          end else begin
            operand_nxt = '0;
            state_nxt   = DECODE;
          end
        end
      end
      FETCH_ARG: begin
        if (fetch_ok) begin
          operand_nxt = mem_rdata;
          pc_nxt      = W'(pc + W'(1));
          state_nxt   = DECODE;
        end
      end
      DECODE: begin
        state_nxt = EXEC;
      end
      EXEC: begin
        if (jump_taken) begin
          pc_nxt = operand;
        end
        if (exec_done) begin
          state_nxt = halt_req ? HALT : FETCH_OP;
        end else begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (exec_done) begin
          state_nxt = halt_req ? HALT : FETCH_OP;
        end
      end
      HALT: begin
        if (!halt_req) begin
          state_nxt = FETCH_OP;
        end
      end
      default: begin
        state_nxt = FETCH_OP;
      end
    endcase
  end

  // State register plus outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH_OP;
      pc         <= '0;
      opcode     <= '0;
      operand    <= '0;
      mem_req    <= 1'b0;
      exec_start <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      opcode     <= opcode_nxt;
      operand    <= operand_nxt;
      mem_req    <= (state_nxt == FETCH_OP) || (state_nxt == FETCH_ARG);
      exec_start <= (state_nxt == EXEC);
      halted     <= (state_nxt == HALT);
    end
  end

  // Fetch address is the program counter itself, stable across wait states
  assign mem_addr = pc;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, single clock; all state changes on its rising edge.
REQ-002 SHALL have port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port `mem_req`: output, 1 bit, program-memory read request.
REQ-004 SHALL have port `mem_addr`: output, 8 bits, program-memory read address, equal to `pc` whenever `mem_req`=1.
REQ-005 SHALL have port `mem_ack`: input, 1 bit, read-data-valid strobe; only sampled while `mem_req`=1.
REQ-006 SHALL have port `mem_rdata`: input, 8 bits, read data, valid when `mem_ack`=1.
REQ-007 SHALL have port `opcode`: output, 8 bits, registered current opcode, fed to the microcode decoder.
REQ-008 SHALL have port `operand`: output, 8 bits, registered operand byte; 0 for opcodes with bit7=0.
REQ-009 SHALL have port `jump_operation`: input, 1 bit, from the microcode decoder.
REQ-010 SHALL have port `jump_condition`: input, 1 bit, from the microcode decoder.
REQ-011 SHALL have ports `carry` and `zero`: inputs, 1 bit each, datapath flags.
REQ-012 SHALL have port `exec_start`: output, 1 bit, one-cycle pulse that launches datapath execution.
REQ-013 SHALL have port `exec_done`: input, 1 bit, datapath completion strobe.
REQ-014 SHALL have port `pc`: output, 8 bits, program counter.
REQ-015 SHALL have port `halt_req`: input, 1 bit, level-sensitive stop request.
REQ-016 SHALL have port `halted`: output, 1 bit, 1 while in state HALT.

Function
REQ-017 SHALL implement the states FETCH_OP, FETCH_ARG, DECODE, EXEC, WAIT_DONE and HALT.
REQ-018 SHALL, in FETCH_OP, assert `mem_req`; on `mem_ack` it latches `mem_rdata` into `opcode` and increments `pc` modulo 256.
REQ-019 SHALL, after FETCH_OP completes, go to FETCH_ARG if opcode bit7=1; otherwise it clears `operand` to 0 and goes to DECODE.
REQ-020 SHALL, in FETCH_ARG, assert `mem_req`; on `mem_ack` it latches `operand`, increments `pc` modulo 256, and goes to DECODE.
REQ-021 SHALL remain in FETCH_OP or FETCH_ARG with `mem_req` held at 1 and `mem_addr` stable for as long as `mem_ack`=0 (unbounded wait states).
REQ-022 SHALL hold DECODE for exactly 1 cycle, which absorbs the registered-decoder latency, then go to EXEC.
REQ-023 SHALL, in EXEC, pulse `exec_start` for 1 cycle and sample `jump_operation`, `jump_condition`, `carry` and `zero`.
REQ-024 SHALL treat a jump as taken when `jump_operation`=1 and either `jump_condition`=0 or the selected flag is 1, where the selected flag is `zero` if opcode bit0=1 and `carry` otherwise.
REQ-025 SHALL, on a taken jump, load `pc` from `operand` at the EXEC edge; a taken jump overrides the increment.
REQ-026 SHALL, in WAIT_DONE, wait for `exec_done`; `exec_done` arriving in the EXEC cycle itself is accepted, so WAIT_DONE is skipped.
REQ-027 SHALL ignore `exec_done` in every state other than EXEC and WAIT_DONE.
REQ-028 SHALL, on completion, go to HALT if `halt_req`=1, otherwise to FETCH_OP.
REQ-029 SHALL sample `halt_req` only at instruction boundaries; an instruction is never aborted mid-flight.
REQ-030 SHALL, in HALT, hold `pc`, `opcode` and `operand` with `mem_req`=0, and return to FETCH_OP on the first cycle `halt_req`=0.
REQ-031 SHALL, for a zero-wait, 1-byte, single-cycle-execute instruction, take 3 cycles (FETCH_OP, DECODE, EXEC); a 2-byte instruction takes 4.
REQ-032 SHALL keep opcode 0x00 (NOP) on the normal path, including `exec_start`.

Reset
REQ-033 SHALL, on `rst_n`=0, immediately force: state FETCH_OP, `pc`=0, `opcode`=0, `operand`=0, `exec_start`=0, `halted`=0.
REQ-034 SHALL drive `mem_req`=0 while `rst_n`=0, and assert `mem_req` on the first clock edge after `rst_n` deasserts.
REQ-035 SHALL, on reset asserted mid-fetch or mid-execute, abandon the instruction; any pending `mem_ack`/`exec_done` is ignored.

Verification
REQ-036 SHALL be verified by this scenario: memory {0x02}, zero wait, `exec_done` tied to 1 -> `mem_req` at pc=0, `exec_start` on cycle 3, `pc`=1, next fetch at addr 1.
REQ-037 SHALL be verified by this scenario: opcode 0x80 with operand 0x5A and 2 wait states per read -> `operand`=0x5A, `pc`=2, `exec_start` exactly once.
REQ-038 SHALL be verified by this scenario: jump opcode with `jump_operation`=1, `jump_condition`=1, `carry`=0 (bit0=0), operand 0x40 -> not taken, `pc`=pc+2; with `carry`=1 -> `pc`=0x40.
REQ-039 SHALL be verified by this scenario: `pc`=0xFF, 1-byte instruction -> `pc` wraps to 0x00.
REQ-040 SHALL be verified by this scenario: `halt_req` raised during WAIT_DONE, `exec_done` 5 cycles later -> `halted`=1 only after `exec_done`, no `mem_req`; drop `halt_req` -> fetch resumes at the held `pc`.
REQ-041 SHALL be verified by this scenario: `rst_n` pulsed low during FETCH_ARG with `mem_ack` high -> `pc`=0, `operand`=0, state FETCH_OP.
